// File: rtl/ether_cmd_rx_if.sv
// ether_cmd_rx_if: SCL/SDA pads plus the decoded register-write outputs of the ether command responder.
interface ether_cmd_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe_out;
    logic [7:0] reg_addr_out;
    logic [7:0] reg_data_out;
    logic       wr_valid_out;
    logic       busy_out;
    logic       frame_err_out;
    modport master (
        output scl_in, sda_in,
        input  sda_oe_out, reg_addr_out, reg_data_out, wr_valid_out, busy_out, frame_err_out
    );
    modport slave (
        input  scl_in, sda_in,
        output sda_oe_out, reg_addr_out, reg_data_out, wr_valid_out, busy_out, frame_err_out
    );
endinterface

// File: rtl/ether_cmd_rx.sv
// ether_cmd_rx: I2C-style write-frame responder; decodes [ADDR+W][CMD][DATA] and strobes the pair out.
module ether_cmd_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h20,
    parameter int         SYNC_STAGES = 2,
    parameter int         GLITCH_LEN  = 3,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic           clk_in,
    input  logic           reset_in,
    ether_cmd_rx_if.slave  bus
);
    localparam int GW = $clog2(GLITCH_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, DATA, DATA_ACK, IGNORE} state_t;
    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [GW-1:0]          r_gcnt [2];
    logic [1:0]             r_filt, r_prev;
    logic [1:0]             w_raw;
    logic [TW-1:0]          r_to_cnt;
    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_bit, w_bit_nxt;
    logic [7:0]             r_shift, w_shift_nxt, r_cmd, w_cmd_nxt, w_byte;
    logic                   r_ack, w_ack_nxt, w_wr_nxt, w_err_nxt;
    logic                   r_wr, r_err;
    logic [7:0]             r_reg_addr, r_reg_data;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop, w_timeout, w_byte_st, w_ack_st;
    assign w_raw = {bus.sda_in, bus.scl_in};
    // index 0 = SCL, 1 = SDA; the filtered level flips only after GLITCH_LEN disagreeing samples in a row
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= '1;
                r_gcnt[i] <= '0;
            end
            r_filt <= '1;
            r_prev <= '1;
        end else begin
            r_prev <= r_filt;
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (r_sync[i][SYNC_STAGES-1] == r_filt[i]) r_gcnt[i] <= '0;
                else if (r_gcnt[i] == GW'(GLITCH_LEN - 1)) begin
                    r_filt[i] <= r_sync[i][SYNC_STAGES-1];
                    r_gcnt[i] <= '0;
                end else r_gcnt[i] <= r_gcnt[i] + 1'b1;
            end
        end
    end
    // START/STOP need SCL high on both samples, so a simultaneous SCL edge wins
    assign w_scl_rise = ~r_prev[0] & r_filt[0];
    assign w_scl_fall = r_prev[0] & ~r_filt[0];
    assign w_start    = r_prev[0] & r_filt[0] & r_prev[1] & ~r_filt[1];
    assign w_stop     = r_prev[0] & r_filt[0] & ~r_prev[1] & r_filt[1];
    assign w_timeout  = r_to_cnt == TW'(TIMEOUT_CYC);
    assign w_byte     = {r_shift[6:0], r_filt[1]};
    assign w_byte_st  = r_state inside {ADDR, CMD, DATA};
    assign w_ack_st   = r_state inside {ADDR_ACK, CMD_ACK, DATA_ACK};
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_cmd_nxt   = r_cmd;
        w_ack_nxt   = r_ack;
        w_wr_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_start) begin
            w_state_nxt = ADDR;
            w_bit_nxt   = 3'd0;
            w_ack_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_ack_nxt   = 1'b0;
            w_err_nxt   = r_state != IDLE && r_state != IGNORE;
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_ack_nxt   = 1'b0;
            w_err_nxt   = 1'b1;
        end else begin
            if (w_byte_st && w_scl_rise) begin
                w_shift_nxt = w_byte;
                w_bit_nxt   = r_bit + 1'b1;
            end
            if (w_byte_st && w_scl_rise && r_bit == 3'd7) begin
                w_state_nxt = (r_state == CMD) ? CMD_ACK : (r_state == DATA) ? DATA_ACK :
                              (w_byte == {DEV_ADDR, 1'b0}) ? ADDR_ACK : IGNORE;
                w_cmd_nxt   = (r_state == CMD) ? w_byte : r_cmd;
            end
            // first SCL fall of an ACK slot pulls SDA low, the second releases it and moves on
            if (w_ack_st && w_scl_fall) begin
                w_ack_nxt = ~r_ack;
                w_wr_nxt  = r_ack && r_state == DATA_ACK;
                if (r_ack) w_state_nxt = (r_state == ADDR_ACK) ? CMD : (r_state == CMD_ACK) ? DATA : IGNORE;
            end
        end
    end
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= IDLE;
            r_bit      <= '0;
            r_shift    <= '0;
            r_cmd      <= '0;
            r_ack      <= 1'b0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_cmd    <= w_cmd_nxt;
            r_ack    <= w_ack_nxt;
            r_wr     <= w_wr_nxt;
            r_err    <= w_err_nxt;
            r_to_cnt <= (r_state == IDLE || w_scl_rise || w_scl_fall || w_timeout) ? '0 : r_to_cnt + 1'b1;
            if (w_wr_nxt) begin
                r_reg_addr <= r_cmd;
                r_reg_data <= r_shift;
            end
        end
    end
    assign bus.sda_oe_out    = r_ack;
    assign bus.reg_addr_out  = r_reg_addr;
    assign bus.reg_data_out  = r_reg_data;
    assign bus.wr_valid_out  = r_wr;
    assign bus.busy_out      = r_state != IDLE;
    assign bus.frame_err_out = r_err;
endmodule

// File: tb/tb_ether_cmd_rx.sv
// tb_ether_cmd_rx: drives ether write frames at SCL = clk/130; strobes are checked against a scoreboard queue.
module tb_ether_cmd_rx;
    localparam int TO   = 4000;
    localparam int HALF = 65;
    localparam int Q    = 32;
    typedef struct {
        logic [7:0] a;
        logic [7:0] c;
        logic [7:0] d;
        logic       g;
        logic       acc;
    } vec_t;
    logic clk_in = 1'b0;
    logic reset_in = 1'b1;
    int cyc = 0, n_cmp = 0, n_bad = 0, err_cnt = 0, oe_rise = 0, busy_cyc = 0, t_fall = 0;
    logic [15:0] sb_q [$];
    logic [7:0] m_addr = '0, m_data = '0;
    logic oe_prev = 1'b0;
    vec_t tbl [7];
    ether_cmd_rx_if bus();
    ether_cmd_rx #(.DEV_ADDR(7'h20), .SYNC_STAGES(2), .GLITCH_LEN(3), .TIMEOUT_CYC(TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .bus(bus));
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    // monitor: pops one expected pair per strobe cycle, so a stretched strobe underflows the queue
    always @(negedge clk_in) begin : mon
        logic [15:0] e;
        if (!reset_in) begin
            if (bus.sda_oe_out && !oe_prev) oe_rise++;
            oe_prev = bus.sda_oe_out;
            if (bus.frame_err_out) err_cnt++;
            if (bus.busy_out) busy_cyc++;
            if (bus.wr_valid_out) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got %0h/%0h want none", bus.reg_addr_out, bus.reg_data_out);
                end else begin
                    e = sb_q.pop_front();
                    check("strobe_addr", bus.reg_addr_out, e[15:8]);
                    check("strobe_data", bus.reg_data_out, e[7:0]);
                    check("strobe_latency", cyc - t_fall, 6);
                    m_addr = e[15:8];
                    m_data = e[7:0];
                end
            end
        end
    end
    task automatic w(int n);
        repeat (n) @(negedge clk_in);
    endtask
    task automatic bit_tx(logic b, logic g);
        w(Q);
        bus.sda_in = b;
        w(HALF - Q);
        bus.scl_in = 1'b1;
        if (g) begin
            w(20); bus.scl_in = 1'b0; w(2); bus.scl_in = 1'b1;
            w(18); bus.sda_in = ~b;   w(2); bus.sda_in = b;
            w(HALF - 42);
        end else w(HALF);
        bus.scl_in = 1'b0;
        t_fall = cyc;
    endtask
    task automatic byte_tx(logic [7:0] v, logic g, output logic ack);
        for (int i = 7; i >= 0; i--) bit_tx(v[i], g);
        w(Q);
        bus.sda_in = 1'b1;
        w(HALF - Q);
        bus.scl_in = 1'b1;
        w(HALF / 2);
        ack = bus.sda_oe_out;
        w(HALF - HALF / 2);
        bus.scl_in = 1'b0;
        t_fall = cyc;
    endtask
    task automatic start_tx();
        if (!bus.scl_in) begin
            w(Q); bus.sda_in = 1'b1; w(HALF - Q); bus.scl_in = 1'b1; w(Q);
        end
        bus.sda_in = 1'b0;
        w(HALF);
        bus.scl_in = 1'b0;
    endtask
    task automatic stop_tx();
        w(Q); bus.sda_in = 1'b0; w(HALF - Q); bus.scl_in = 1'b1; w(Q); bus.sda_in = 1'b1; w(HALF);
    endtask
    task automatic frame_tx(logic [7:0] a, logic [7:0] c, logic [7:0] d, logic g,
                            output logic [2:0] acks, output logic bz);
        logic k0, k1, k2;
        start_tx();
        byte_tx(a, g, k2);
        byte_tx(c, g, k1);
        byte_tx(d, g, k0);
        acks = {k2, k1, k0};
        bz = bus.busy_out;
        stop_tx();
    endtask
    initial begin #(10 * 95000); $display("FAIL watchdog: run exceeded 95000 cycles"); $fatal(1); end
    initial begin
        logic [2:0] acks;
        logic bz, k;
        int oe0, e0, b0;
        tbl = '{'{8'h40, 8'h03, 8'h00, 1'b0, 1'b1}, '{8'h40, 8'h01, 8'hF9, 1'b0, 1'b1},
                '{8'h42, 8'h55, 8'hAA, 1'b0, 1'b0}, '{8'h41, 8'h55, 8'hAA, 1'b0, 1'b0},
                '{8'h40, 8'h03, 8'h00, 1'b1, 1'b1}, '{8'h40, 8'hA5, 8'h5A, 1'b0, 1'b1},
                '{8'h40, 8'hFF, 8'hFF, 1'b0, 1'b1}};
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        w(3);
        check("rst_outputs", {bus.sda_oe_out, bus.reg_addr_out, bus.reg_data_out, bus.wr_valid_out, bus.busy_out, bus.frame_err_out}, 0);
        reset_in = 1'b0;
        w(10);
        check("rst_busy", bus.busy_out, 0);
        e0 = err_cnt; b0 = busy_cyc;
        bus.scl_in = 1'b0; w(2); bus.scl_in = 1'b1; w(10);
        bus.sda_in = 1'b0; w(2); bus.sda_in = 1'b1; w(20);
        check("idle_glitch_busy", busy_cyc - b0, 0);
        check("idle_glitch_err", err_cnt - e0, 0);
        for (int i = 0; i < 7; i++) begin
            oe0 = oe_rise; e0 = err_cnt;
            if (tbl[i].acc) sb_q.push_back({tbl[i].c, tbl[i].d});
            frame_tx(tbl[i].a, tbl[i].c, tbl[i].d, tbl[i].g, acks, bz);
            w(10);
            check("ack_slots", acks, tbl[i].acc ? 3'b111 : 3'b000);
            check("oe_rises", oe_rise - oe0, tbl[i].acc ? 3 : 0);
            check("busy_before_stop", bz, 1);
            check("busy_after_stop", bus.busy_out, 0);
            check("no_frame_err", err_cnt - e0, 0);
            check("queue_drained", sb_q.size(), 0);
            check("reg_addr", bus.reg_addr_out, m_addr);
            check("reg_data", bus.reg_data_out, m_data);
        end
        e0 = err_cnt;
        start_tx(); byte_tx(8'h40, 1'b0, k); byte_tx(8'h77, 1'b0, k);
        for (int i = 0; i < 4; i++) bit_tx(i[0], 1'b0);
        stop_tx();
        w(10);
        check("early_stop_err", err_cnt - e0, 1);
        check("early_stop_busy", bus.busy_out, 0);
        check("early_stop_addr", bus.reg_addr_out, m_addr);
        check("early_stop_data", bus.reg_data_out, m_data);
        e0 = err_cnt;
        start_tx(); byte_tx(8'h40, 1'b0, k);
        for (int i = 0; i < 3; i++) bit_tx(1'b1, 1'b0);
        w(20);
        check("frozen_busy", bus.busy_out, 1);
        w(TO - 20);
        check("timeout_not_early", err_cnt - e0, 0);
        for (int i = 0; i < 200 && err_cnt == e0; i++) w(1);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_busy", bus.busy_out, 0);
        bus.sda_in = 1'b0; w(10); bus.scl_in = 1'b1; w(10); bus.sda_in = 1'b1; w(20);
        check("idle_stop_no_err", err_cnt - e0, 1);
        e0 = err_cnt; oe0 = oe_rise;
        start_tx(); byte_tx(8'h40, 1'b0, k); byte_tx(8'h11, 1'b0, k);
        sb_q.push_back(16'h2233);
        start_tx(); byte_tx(8'h40, 1'b0, k); byte_tx(8'h22, 1'b0, k); byte_tx(8'h33, 1'b0, k);
        stop_tx();
        w(10);
        check("rstart_err", err_cnt - e0, 0);
        check("rstart_oe_rises", oe_rise - oe0, 5);
        check("rstart_queue", sb_q.size(), 0);
        check("rstart_addr", bus.reg_addr_out, 8'h22);
        check("rstart_data", bus.reg_data_out, 8'h33);
        start_tx(); byte_tx(8'h40, 1'b0, k); byte_tx(8'h44, 1'b0, k);
        for (int i = 0; i < 3; i++) bit_tx(1'b1, 1'b0);
        w(Q);
        reset_in = 1'b1;
        #1;
        check("async_rst_outputs", {bus.sda_oe_out, bus.reg_addr_out, bus.reg_data_out, bus.wr_valid_out, bus.busy_out, bus.frame_err_out}, 0);
        m_addr = '0; m_data = '0;
        bus.scl_in = 1'b1; bus.sda_in = 1'b1;
        w(5);
        reset_in = 1'b0;
        w(10);
        sb_q.push_back(16'h0300);
        frame_tx(8'h40, 8'h03, 8'h00, 1'b0, acks, bz);
        w(10);
        check("post_rst_acks", acks, 3'b111);
        check("post_rst_queue", sb_q.size(), 0);
        check("post_rst_addr", bus.reg_addr_out, 8'h03);
        check("post_rst_data", bus.reg_data_out, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
